apu_ram_arbiter: RTL and testbench
==================================

# apu_ram_arbiter

- Shares the single-port 64 KiB APU RAM among three requesters: the DSP voice fetcher, the SPC700 CPU core and the UART host loader.
- Sits between those masters and the RAM macro and owns `ram_address`, `ram_data_write` and `ram_we`.
- Uses fixed priority with starvation protection for the host path, and runs one access in flight with a req/ack handshake per requester.

## Interface
- `READ_LATENCY`, 1: RAM cycles from address sampled to `ram_data_read` valid (1..4).
- `STARVE_LIMIT`, 8: lost arbitration decisions after which a waiting host request wins.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `dsp_req`, `dsp_addr`  in  1, 16  DSP read request (read-only master).
- `dsp_ack`, `dsp_rdata`  out  1, 8  one-cycle ack with read data.
- `cpu_req`, `cpu_we`, `cpu_addr`, `cpu_wdata`  in  1, 1, 16, 8  CPU access.
- `cpu_ack`, `cpu_rdata`  out  1, 8
- `host_req`, `host_we`, `host_addr`, `host_wdata`  in  1, 1, 16, 8  UART loader access.
- `host_ack`, `host_rdata`  out  1, 8
- `ram_address`, `ram_data_write`, `ram_we`  out  16, 8, 1  RAM port.
- `ram_data_read`  in  8  synchronous RAM output.
- `grant_id`  out  2  0 none, 1 DSP, 2 CPU, 3 host; the current owner, for debug.

## Operation
- States: IDLE, ISSUE, ACK.
- **Priority:** DSP > CPU > host, except when `host_wait == STARVE_LIMIT`; then host wins over both.
- **IDLE:** if any request is eligible, latch the winner's address, data and we into the RAM outputs, set `grant_id`, and go to ISSUE. Otherwise hold, with `ram_we` = 0.
- **ISSUE, write:** `ram_we` = 1 for exactly this one cycle, then go to ACK.
- **ISSUE, read:** stay `READ_LATENCY+1` cycles. On the exit edge, capture `ram_data_read` into the owner's rdata register, then go to ACK.
- **ACK:** the owner's ack is 1 for exactly one cycle and `ram_we` = 0. The arbitration of IDLE runs in the same cycle with the just-acked requester masked. A winner goes straight to ISSUE; otherwise the next state is IDLE.
- **Handshake:** a requester holds req, addr, we and wdata stable until it sees ack. It may drop req in the ack cycle, or keep it high for a back-to-back access, which is re-eligible from the following cycle.
- **Unexpected req drop:** if req drops after grant, the access still completes and ack still pulses.
- **Data hold:** rdata registers keep their value until that requester's next read completes.
- **`host_wait` (4 bits, saturating):**
  - +1 on each grant to DSP or CPU while `host_req` = 1.
  - Cleared on a host grant or when `host_req` = 0.
- **Reset:** aborts any access with no ack issued. All outputs go to 0, the state to IDLE, `host_wait` to 0 and `grant_id` to 0.

## Timing
- Write: req seen at edge E0 → `ram_we` high after E0 → ack high after E1.
- Read: req seen at edge E0 → ack high after `E0+READ_LATENCY+1`, with rdata valid in the same cycle.
- Back-to-back throughput between different requesters: a write every 2 cycles; a read every `READ_LATENCY+2` cycles.
- Simultaneous requests are resolved in a single cycle. At most one ack is high in any cycle.
- `ram_address` holds the last granted address in IDLE; there is no requirement to return it to 0.

## Structure
- Shared package `apu_pkg` holds:
  - requester id constants `REQ_NONE`, `REQ_DSP`, `REQ_CPU`, `REQ_HOST`;
  - the arbiter state encoding;
  - the RAM address and data widths.
- One sub-module, `apu_ram_arb_pick`: combinational priority and starvation select, taking req, mask and `host_wait` and returning the winner id. Everything else stays in the top.

## Test plan
- **Single host write:** `host_we`=1, addr 0x0200, data 0xA5.
  - `ram_we` is high for exactly 1 cycle with 0x0200/0xA5.
  - `host_ack` pulses 2 cycles after req.
- **CPU read-back:** CPU read of 0x0200 after the host write, `READ_LATENCY`=1.
  - `cpu_ack` pulses 3 edges after req, with `cpu_rdata`=0xA5.
- **Simultaneous requests:** DSP, CPU and host all request in the same cycle.
  - Grant order is DSP, CPU, host.
  - Acks never overlap, and each owner's data is correct.
- **Host starvation:** host req held while DSP and CPU keep requesting continuously.
  - The host is granted right after the 8th lost grant, and `host_wait` clears.
- **Reset mid-access:** assert `reset` during a read ISSUE.
  - No ack is issued and all outputs go to 0.
  - After release, a new CPU write completes normally.
- **Parameter sweep:** `READ_LATENCY`=3.
  - Read ack latency is 5 edges.
  - Back-to-back CPU reads are spaced 5 cycles apart.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared definitions for the APU RAM arbiter.
//   - RAM address/data widths and host starvation counter width
//   - requester id constants (also the grant_id encoding)
//   - arbiter state encoding and the latched RAM operation record
package apu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_DSP  = 2'd1;
  localparam logic [1:0] REQ_CPU  = 2'd2;
  localparam logic [1:0] REQ_HOST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_op_t;

endpackage

// File: rtl/apu_ram_arb_pick.sv
// apu_ram_arb_pick: combinational winner select.
//   req[2:0]   requests, bit0 DSP, bit1 CPU, bit2 host
//   mask[2:0]  requesters excluded from this decision (just acked)
//   host_wait  lost-decision count for the host
//   winner     REQ_* id of the winner, REQ_NONE when nobody is eligible
module apu_ram_arb_pick
  import apu_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic [2:0]        req,
  input  logic [2:0]        mask,
  input  logic [WAIT_W-1:0] host_wait,
  output logic [1:0]        winner
);

  logic [2:0] elig;
  assign elig = req & ~mask;

  always_comb begin
    winner = REQ_NONE;
    // A starved host overrides the fixed DSP > CPU > host order.
    if (elig[2] && (host_wait == WAIT_W'(STARVE_LIMIT))) winner = REQ_HOST;
    else if (elig[0])                                     winner = REQ_DSP;
    else if (elig[1])                                     winner = REQ_CPU;
    else if (elig[2])                                     winner = REQ_HOST;
  end

endmodule

// File: rtl/apu_ram_arbiter.sv
// apu_ram_arbiter: shares the single-port APU RAM between the DSP voice
// fetcher (read-only), the SPC700 CPU and the UART host loader.
//   dsp_*  : req/addr in, ack/rdata out
//   cpu_*  : req/we/addr/wdata in, ack/rdata out
//   host_* : req/we/addr/wdata in, ack/rdata out
//   ram_*  : address/data_write/we to the RAM macro, data_read back
//   grant_id : current owner (0 none, 1 DSP, 2 CPU, 3 host)
// One access in flight: IDLE -> ISSUE (1 cycle write, READ_LATENCY+1 read)
// -> ACK. ACK re-arbitrates with the just-acked requester masked.
module apu_ram_arbiter
  import apu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_ack,
  output logic [DATA_W-1:0] dsp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_write,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_read,
  output logic [1:0]        grant_id
);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  ram_op_t           op_q, op_d;
  logic              ram_we_q, ram_we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WAIT_W-1:0] host_wait_q, host_wait_d;
  logic [DATA_W-1:0] dsp_rdata_q, dsp_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic [2:0] req_vec, mask;
  logic [1:0] win_id;
  logic       grant;
  ram_op_t    win_op;

  assign req_vec = {host_req, cpu_req, dsp_req};
  // Only the ACK cycle masks its owner, so a held req waits one cycle.
  assign mask = (state_q == ST_ACK) ?
                {grant_q == REQ_HOST, grant_q == REQ_CPU, grant_q == REQ_DSP} : 3'b000;

  apu_ram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .req      (req_vec),
    .mask     (mask),
    .host_wait(host_wait_q),
    .winner   (win_id)
  );

  assign grant = ((state_q == ST_IDLE) || (state_q == ST_ACK)) && (win_id != REQ_NONE);

  always_comb begin
    win_op = '0;
    case (win_id)
      REQ_DSP:  win_op = '{we: 1'b0,    addr: dsp_addr,  wdata: '0};
      REQ_CPU:  win_op = '{we: cpu_we,  addr: cpu_addr,  wdata: cpu_wdata};
      REQ_HOST: win_op = '{we: host_we, addr: host_addr, wdata: host_wdata};
      default:  win_op = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    op_d         = op_q;
    ram_we_d     = 1'b0;
    cnt_d        = cnt_q;
    dsp_rdata_d  = dsp_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      ST_IDLE, ST_ACK: begin
        if (grant) begin
          state_d  = ST_ISSUE;
          grant_d  = win_id;
          op_d     = win_op;
          ram_we_d = win_op.we;
          cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = REQ_NONE;
        end
      end
      ST_ISSUE: begin
        if (op_q.we) begin
          state_d = ST_ACK;
        end else if (cnt_q == 3'(READ_LATENCY)) begin
          state_d = ST_ACK;
          case (grant_q)
            REQ_DSP:  dsp_rdata_d  = ram_data_read;
            REQ_CPU:  cpu_rdata_d  = ram_data_read;
            REQ_HOST: host_rdata_d = ram_data_read;
            default:  ;
          endcase
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Saturating count of decisions the waiting host lost.
    host_wait_d = host_wait_q;
    if (!host_req || (grant && win_id == REQ_HOST))
      host_wait_d = '0;
    else if (grant && host_wait_q != '1)
      host_wait_d = host_wait_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_NONE;
      op_q         <= '0;
      ram_we_q     <= 1'b0;
      cnt_q        <= '0;
      host_wait_q  <= '0;
      dsp_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      ram_we_q     <= ram_we_d;
      cnt_q        <= cnt_d;
      host_wait_q  <= host_wait_d;
      dsp_rdata_q  <= dsp_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign ram_address    = op_q.addr;
  assign ram_data_write = op_q.wdata;
  assign ram_we         = ram_we_q;
  assign grant_id       = grant_q;
  assign dsp_ack        = (state_q == ST_ACK) && (grant_q == REQ_DSP);
  assign cpu_ack        = (state_q == ST_ACK) && (grant_q == REQ_CPU);
  assign host_ack       = (state_q == ST_ACK) && (grant_q == REQ_HOST);
  assign dsp_rdata      = dsp_rdata_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign host_rdata     = host_rdata_q;

endmodule

// File: tb/tb_apu_ram_arbiter.sv
// Bench for apu_ram_arbiter: one instance at READ_LATENCY=1 and one at
// READ_LATENCY=3, sharing the request inputs, each with its own RAM model.
module tb_apu_ram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        dsp_req = 0, cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
  logic [15:0] dsp_addr = 0, cpu_addr = 0, host_addr = 0;
  logic [7:0]  cpu_wdata = 0, host_wdata = 0;

  logic        dsp_ack, cpu_ack, host_ack, ram_we;
  logic [7:0]  dsp_rdata, cpu_rdata, host_rdata, ram_data_write, ram_data_read;
  logic [15:0] ram_address;
  logic [1:0]  grant_id;

  logic        s_dsp_ack, s_cpu_ack, s_host_ack, s_ram_we;
  logic [7:0]  s_dsp_rdata, s_cpu_rdata, s_host_rdata, s_ram_data_write, s_ram_data_read;
  logic [15:0] s_ram_address;
  logic [1:0]  s_grant_id;

  apu_ram_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_ack(dsp_ack), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_address(ram_address), .ram_data_write(ram_data_write), .ram_we(ram_we),
    .ram_data_read(ram_data_read), .grant_id(grant_id)
  );

  apu_ram_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(8)) dut3 (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_ack(s_dsp_ack), .dsp_rdata(s_dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(s_host_ack), .host_rdata(s_host_rdata),
    .ram_address(s_ram_address), .ram_data_write(s_ram_data_write), .ram_we(s_ram_we),
    .ram_data_read(s_ram_data_read), .grant_id(s_grant_id)
  );

  // RAM models: contents start as addr[7:0]^addr[15:8].
  logic [7:0] mem  [0:65535];
  logic [7:0] mem3 [0:65535];
  logic [7:0] p1, p2;
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 8'(i) ^ 8'(i >> 8);
      mem3[i] = 8'(i) ^ 8'(i >> 8);
    end
  end
  always @(posedge clock) begin
    if (ram_we) mem[ram_address] <= ram_data_write;
    ram_data_read <= mem[ram_address];
  end
  always @(posedge clock) begin
    if (s_ram_we) mem3[s_ram_address] <= s_ram_data_write;
    p1 <= mem3[s_ram_address];
    p2 <= p1;
    s_ram_data_read <= p2;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // At most one ack per cycle on either instance.
  always @(negedge clock) begin
    if (dsp_ack | cpu_ack | host_ack) begin
      total++;
      if ($countones({dsp_ack, cpu_ack, host_ack}) > 1) begin
        bad++;
        $display("FAIL ack_overlap: acks=%b want one-hot", {dsp_ack, cpu_ack, host_ack});
      end
    end
    if (s_dsp_ack | s_cpu_ack | s_host_ack) begin
      total++;
      if ($countones({s_dsp_ack, s_cpu_ack, s_host_ack}) > 1) begin
        bad++;
        $display("FAIL ack_overlap3: acks=%b want one-hot", {s_dsp_ack, s_cpu_ack, s_host_ack});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      1: return dsp_ack;
      2: return cpu_ack;
      default: return host_ack;
    endcase
  endfunction

  function automatic logic [7:0] rdata_of(input int who);
    case (who)
      1: return dsp_rdata;
      2: return cpu_rdata;
      default: return host_rdata;
    endcase
  endfunction

  task automatic set_req(input int who, input logic r, input logic we,
                         input logic [15:0] a, input logic [7:0] wd);
    case (who)
      1: begin dsp_req = r; dsp_addr = a; end
      2: begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
      default: begin host_req = r; host_we = we; host_addr = a; host_wdata = wd; end
    endcase
  endtask

  typedef struct {
    int          who;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          lat;
    logic [7:0]  rd;
  } vec_t;

  // One access from IDLE on the READ_LATENCY=1 instance.
  task automatic do_access(input vec_t v, input string nm);
    int lat = 0, we_cnt = 0;
    logic got = 0;
    set_req(v.who, 1'b1, v.we, v.addr, v.wd);
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      lat++;
      if (ram_we) begin
        we_cnt++;
        check({nm, "_waddr"}, ram_address, v.addr);
        check({nm, "_wdata"}, ram_data_write, v.wd);
      end
      if (ack_of(v.who)) got = 1;
    end
    check({nm, "_acked"}, got, 1);
    check({nm, "_lat"}, lat, v.lat);
    check({nm, "_we_cycles"}, we_cnt, v.we ? 1 : 0);
    if (!v.we) check({nm, "_rdata"}, rdata_of(v.who), v.rd);
    set_req(v.who, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    check({nm, "_ack_one_cycle"}, ack_of(v.who), 0);
    check({nm, "_we_after"}, ram_we, 0);
  endtask

  vec_t tbl [8];
  int   order [3];
  int   n, lat, losses, t_dsp, t_cpu, t_host, t1, t2;
  logic host_done;

  initial begin
    tbl[0] = '{3, 1'b1, 16'h0200, 8'hA5, 2, 8'h00};
    tbl[1] = '{2, 1'b0, 16'h0200, 8'h00, 3, 8'hA5};
    tbl[2] = '{2, 1'b1, 16'h1234, 8'h3C, 2, 8'h00};
    tbl[3] = '{1, 1'b0, 16'h1234, 8'h00, 3, 8'h3C};
    tbl[4] = '{3, 1'b0, 16'h0200, 8'h00, 3, 8'hA5};
    tbl[5] = '{2, 1'b1, 16'hFFFF, 8'h5A, 2, 8'h00};
    tbl[6] = '{3, 1'b0, 16'hFFFF, 8'h00, 3, 8'h5A};
    tbl[7] = '{1, 1'b0, 16'h0301, 8'h00, 3, 8'h02};

    // Reset state.
    #2;
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_address, 0);
    check("rst_grant", grant_id, 0);
    check("rst_acks", {dsp_ack, cpu_ack, host_ack}, 0);
    tick();
    reset = 0;
    tick();

    foreach (tbl[i]) do_access(tbl[i], $sformatf("vec%0d", i));

    // Simultaneous requests: DSP read, CPU write, host read.
    set_req(1, 1, 0, 16'h0200, 8'h00);
    set_req(2, 1, 1, 16'h0400, 8'h77);
    set_req(3, 1, 0, 16'h1234, 8'h00);
    n = 0; lat = 0; t_dsp = 0; t_cpu = 0; t_host = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      tick();
      lat++;
      if (dsp_ack)  begin order[n] = 1; n++; t_dsp = lat;  dsp_req = 0;  end
      if (cpu_ack)  begin order[n] = 2; n++; t_cpu = lat;  cpu_req = 0;  end
      if (host_ack) begin order[n] = 3; n++; t_host = lat; host_req = 0; end
    end
    check("sim_count", n, 3);
    check("sim_first", order[0], 1);
    check("sim_second", order[1], 2);
    check("sim_third", order[2], 3);
    check("sim_t_dsp", t_dsp, 3);
    check("sim_t_cpu", t_cpu, 5);
    check("sim_t_host", t_host, 8);
    check("sim_dsp_rdata", dsp_rdata, 8'hA5);
    check("sim_host_rdata", host_rdata, 8'h3C);
    check("sim_cpu_write", mem[16'h0400], 8'h77);
    dsp_req = 0; cpu_req = 0; host_req = 0;
    tick(); tick();

    // Host starvation with DSP and CPU requesting back to back.
    set_req(1, 1, 0, 16'h0010, 8'h00);
    set_req(2, 1, 0, 16'h0020, 8'h00);
    set_req(3, 1, 1, 16'h0500, 8'h99);
    losses = 0; host_done = 0;
    for (int c = 0; c < 80 && !host_done; c++) begin
      tick();
      if (dsp_ack || cpu_ack) losses++;
      if (grant_id == 2'd3 && !host_done && !host_ack)
        check("starve_wait_cleared", dut.host_wait_q, 0);
      if (host_ack) host_done = 1;
    end
    check("starve_host_acked", host_done, 1);
    check("starve_losses", losses, 8);
    check("starve_dsp_rdata", dsp_rdata, 8'h10);
    check("starve_cpu_rdata", cpu_rdata, 8'h20);
    dsp_req = 0; cpu_req = 0; host_req = 0;
    for (int c = 0; c < 6; c++) tick();
    check("starve_host_write", mem[16'h0500], 8'h99);

    // Reset during a read ISSUE.
    set_req(2, 1, 0, 16'h0200, 8'h00);
    tick();
    check("rstmid_in_issue", grant_id, 2);
    reset = 1;
    #1;
    check("rstmid_ram_we", ram_we, 0);
    check("rstmid_addr", ram_address, 0);
    check("rstmid_grant", grant_id, 0);
    check("rstmid_acks", {dsp_ack, cpu_ack, host_ack}, 0);
    check("rstmid_rdata", {dsp_rdata, cpu_rdata, host_rdata}, 0);
    cpu_req = 0;
    tick();
    reset = 0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cpu_ack) n++;
    end
    check("rstmid_no_ack", n, 0);
    do_access('{2, 1'b1, 16'h0600, 8'h42, 2, 8'h00}, "post_rst_write");
    check("post_rst_mem", mem[16'h0600], 8'h42);

    // READ_LATENCY=3 instance: latency and back-to-back spacing.
    reset = 1;
    tick();
    reset = 0;
    tick();
    set_req(2, 1, 0, 16'h0301, 8'h00);
    lat = 0; t1 = 0; t2 = 0;
    for (int c = 0; c < 40 && t2 == 0; c++) begin
      tick();
      lat++;
      if (s_cpu_ack) begin
        if (t1 == 0) begin
          t1 = lat;
          check("rl3_rdata", s_cpu_rdata, 8'h02);
        end else t2 = lat;
      end
    end
    cpu_req = 0;
    check("rl3_lat", t1, 5);
    // Held req: ack, masked IDLE cycle, 4 ISSUE cycles, ack -> 5 cycles between acks.
    check("rl3_gap", t2 - t1 - 1, 5);
    for (int c = 0; c < 8; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
